dmem_unit: RTL and testbench

- Parametrised data-memory unit for the MEM stage of the RV32 pipeline.
- Successor to the fixed word-only, zero-latency data memory.
- Adds byte, halfword and word loads/stores selected by funct3, with sign/zero extension.
- Adds a configurable base address and depth, a configurable load latency with a valid/ready handshake, and fault reporting (misaligned, out-of-range, illegal funct3) in place of silent zero reads.

---
 rtl/dmem_pkg.sv | 10 +
 rtl/dmem_align.sv | 34 +++
 rtl/dmem_unit.sv | 78 +++++++
 tb/tb_dmem_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, fault codes and FSM states for the data-memory unit
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {FLT_NONE, FLT_MISALIGN, FLT_RANGE, FLT_ILLEGAL} fault_e;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
endpackage

// File: rtl/dmem_align.sv
// dmem_align: byte-lane enables, store replication, load extraction/extension and
// illegal/misaligned detection for one request
module dmem_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        illegal
);
  logic [31:0] sh;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    illegal = we ? (funct3 > F3_W) : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misalign = (funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
    be = funct3[1:0] == 2'b00 ? 4'b0001 << addr_lo :
         funct3[1:0] == 2'b01 ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wword = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
            funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    sh = rword >> {addr_lo, 3'b000};
    b = sh[7:0];
    h = addr_lo[1] ? rword[31:16] : rword[15:0];
    // funct3[2] marks the unsigned variants
    rdata = funct3[1:0] == 2'b00 ? {{24{b[7] & ~funct3[2]}}, b} :
            funct3[1:0] == 2'b01 ? {{16{h[15] & ~funct3[2]}}, h} : rword;
  end
endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: MEM-stage data memory with byte/half/word access, configurable load
// latency, valid/ready handshake and fault reporting
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          LOAD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_fault,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH_WORDS);
  // BASE_ADDR is aligned to the array size, so range reduces to matching upper bits
  localparam logic [31:0] MASK = ~(32'(DEPTH_WORDS) * 32'd4 - 32'd1);
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
  state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] be;
  logic [31:0] wword, ext;
  logic misalign, illegal, accept;
  logic [AW-1:0] idx;
  fault_e flt;
  assign idx = AW'((req_addr - BASE_ADDR) >> 2);
  assign flt = illegal ? FLT_ILLEGAL : misalign ? FLT_MISALIGN :
               (req_addr & MASK) != BASE_ADDR ? FLT_RANGE : FLT_NONE;
  assign req_ready = state == ST_IDLE || state == ST_RESP;
  assign stall = ~req_ready;
  assign rsp_valid = state == ST_RESP;
  assign accept = req_valid && req_ready;
  dmem_align u_align (
    .we(req_we), .funct3(req_funct3), .addr_lo(req_addr[1:0]), .wdata(req_wdata),
    .rword(mem[idx]), .be(be), .wword(wword), .rdata(ext), .misalign(misalign), .illegal(illegal)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == ST_WAIT) begin
      cnt_n = cnt - 4'd1;
      state_n = cnt == 4'd1 ? ST_RESP : ST_WAIT;
    end else if (accept) begin
      state_n = (!req_we && flt == FLT_NONE && LOAD_LATENCY > 1) ? ST_WAIT : ST_RESP;
      cnt_n = state_n == ST_WAIT ? 4'(LOAD_LATENCY - 1) : 4'd0;
    end else begin
      state_n = ST_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      rsp_rdata <= '0;
      rsp_fault <= FLT_NONE;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        rsp_rdata <= (!req_we && flt == FLT_NONE) ? ext : '0;
        rsp_fault <= flt;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept && req_we && flt == FLT_NONE)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: three differently-parameterised units checked against a byte-level model
module tb_dmem_unit;
  localparam logic [31:0] BASE [3] = '{32'h0, 32'h8000_0000, 32'h0};
  localparam int DEP [3] = '{1024, 256, 16};
  localparam int LAT [3] = '{1, 3, 4};

  logic clk = 0;
  always #5 clk = ~clk;

  logic rst [3], req_valid [3], req_ready [3], req_we [3], rsp_valid [3], stall [3];
  logic [2:0] f3 [3];
  logic [31:0] addr [3], wdata [3], rdata [3];
  logic [1:0] fault [3];

  dmem_unit #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LOAD_LATENCY(1)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(f3[0]), .req_addr(addr[0]), .req_wdata(wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rdata[0]), .rsp_fault(fault[0]), .stall(stall[0]));
  dmem_unit #(.DEPTH_WORDS(256), .BASE_ADDR(32'h8000_0000), .LOAD_LATENCY(3)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(f3[1]), .req_addr(addr[1]), .req_wdata(wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rdata[1]), .rsp_fault(fault[1]), .stall(stall[1]));
  dmem_unit #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LOAD_LATENCY(4)) u2 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
    .req_funct3(f3[2]), .req_addr(addr[2]), .req_wdata(wdata[2]), .rsp_valid(rsp_valid[2]),
    .rsp_rdata(rdata[2]), .rsp_fault(fault[2]), .stall(stall[2]));

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    for (int u = 0; u < 3; u++)
      check($sformatf("stall_vs_ready[%0d]", u), 32'(stall[u]), 32'(!req_ready[u]));

  // byte-addressed memory model, keyed by {unit, address}
  bit [7:0] bm [bit [33:0]];

  function automatic bit [7:0] rdb(input int u, input bit [31:0] a);
    bit [33:0] key = {u[1:0], a};
    return bm.exists(key) ? bm[key] : 8'h00;
  endfunction

  task automatic model(input int u, input bit we, input bit [2:0] f, input bit [31:0] a,
                       input bit [31:0] wd, output bit [31:0] rd, output bit [1:0] flt, output int lat);
    int sz = 1 << f[1:0];
    longint lo = longint'(BASE[u]);
    longint hi = lo + longint'(DEP[u]) * 4;
    bit legal = we ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    longint v = 0;
    rd = 0;
    lat = 1;
    if (!legal) flt = 2'd3;
    else if (a % sz != 0) flt = 2'd1;
    else if (longint'(a) < lo || longint'(a) >= hi) flt = 2'd2;
    else begin
      flt = 2'd0;
      if (we) begin
        for (int i = 0; i < sz; i++) bm[{u[1:0], a + 32'(i)}] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) v |= longint'(rdb(u, a + 32'(i))) << (8 * i);
        if (!f[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
        rd = v[31:0];
        lat = LAT[u];
      end
    end
  endtask

  task automatic xact(input int u, input bit we, input bit [2:0] f, input bit [31:0] a, input bit [31:0] wd,
                      output logic [31:0] rd, output logic [1:0] flt, output bit [31:0] erd, output bit [1:0] eflt);
    int lat, k;
    @(negedge clk);
    req_valid[u] = 1; req_we[u] = we; f3[u] = f; addr[u] = a; wdata[u] = wd;
    @(posedge clk);
    #1 req_valid[u] = 0;
    model(u, we, f, a, wd, erd, eflt, lat);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rsp_valid[u]) break;
      check($sformatf("ready_in_wait u%0d", u), 32'(req_ready[u]), 32'd0);
    end
    check($sformatf("latency u%0d a=%h", u, a), 32'(k), 32'(lat));
    rd = rdata[u];
    flt = fault[u];
  endtask

  typedef struct { int u; bit we; bit [2:0] f; bit [31:0] a, wd, erd; bit [1:0] ef; } vec_t;
  vec_t tbl [$];

  initial begin
    logic [31:0] rd;
    logic [1:0] flt;
    bit [31:0] erd;
    bit [1:0] eflt;
    int lat;
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1; req_valid[u] = 0; req_we[u] = 0; f3[u] = 0; addr[u] = 0; wdata[u] = 0;
    end
    #12;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst_ready u%0d", u), 32'(req_ready[u]), 32'd1);
      check($sformatf("rst_stall u%0d", u), 32'(stall[u]), 32'd0);
      check($sformatf("rst_valid u%0d", u), 32'(rsp_valid[u]), 32'd0);
      check($sformatf("rst_rdata u%0d", u), rdata[u], 32'd0);
      check($sformatf("rst_fault u%0d", u), 32'(fault[u]), 32'd0);
    end
    @(negedge clk);
    for (int u = 0; u < 3; u++) rst[u] = 0;

    tbl.push_back('{0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 2'd0});
    tbl.push_back('{0, 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 2'd0});
    tbl.push_back('{0, 1, 3'd0, 32'h13, 32'h7F, 32'h0, 2'd0});
    tbl.push_back('{0, 0, 3'd2, 32'h10, 32'h0, 32'h7FADBEEF, 2'd0});
    tbl.push_back('{0, 0, 3'd0, 32'h12, 32'h0, 32'hFFFFFFAD, 2'd0});
    tbl.push_back('{0, 0, 3'd4, 32'h12, 32'h0, 32'h000000AD, 2'd0});
    tbl.push_back('{0, 0, 3'd1, 32'h12, 32'h0, 32'h00007FAD, 2'd0});
    tbl.push_back('{0, 0, 3'd5, 32'h10, 32'h0, 32'h0000BEEF, 2'd0});
    tbl.push_back('{0, 0, 3'd1, 32'h10, 32'h0, 32'hFFFFBEEF, 2'd0});
    tbl.push_back('{0, 0, 3'd2, 32'h6, 32'h0, 32'h0, 2'd1});
    tbl.push_back('{0, 1, 3'd2, 32'h1000, 32'hCAFEF00D, 32'h0, 2'd2});
    tbl.push_back('{0, 0, 3'd2, 32'h0, 32'h0, 32'h0, 2'd0});
    tbl.push_back('{0, 0, 3'd3, 32'h10, 32'h0, 32'h0, 2'd3});
    tbl.push_back('{0, 1, 3'd1, 32'h11, 32'h1234, 32'h0, 2'd1});
    tbl.push_back('{0, 1, 3'd4, 32'h10, 32'h1234, 32'h0, 2'd3});
    tbl.push_back('{0, 0, 3'd7, 32'h1001, 32'h0, 32'h0, 2'd3});
    tbl.push_back('{0, 0, 3'd2, 32'h1002, 32'h0, 32'h0, 2'd1});
    tbl.push_back('{0, 0, 3'd2, 32'h10, 32'h0, 32'h7FADBEEF, 2'd0});
    tbl.push_back('{1, 0, 3'd2, 32'h7FFFFFFC, 32'h0, 32'h0, 2'd2});
    tbl.push_back('{1, 1, 3'd2, 32'h80000000, 32'h11223344, 32'h0, 2'd0});
    tbl.push_back('{1, 0, 3'd2, 32'h80000000, 32'h0, 32'h11223344, 2'd0});
    tbl.push_back('{1, 0, 3'd5, 32'h80000002, 32'h0, 32'h00001122, 2'd0});
    tbl.push_back('{1, 0, 3'd1, 32'h80000000, 32'h0, 32'h00003344, 2'd0});
    tbl.push_back('{1, 0, 3'd2, 32'h80000400, 32'h0, 32'h0, 2'd2});
    foreach (tbl[i]) begin
      xact(tbl[i].u, tbl[i].we, tbl[i].f, tbl[i].a, tbl[i].wd, rd, flt, erd, eflt);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].erd);
      check($sformatf("vec%0d_fault", i), 32'(flt), 32'(tbl[i].ef));
    end

    // second request held off during a 3-cycle load, then accepted in the RESP cycle
    model(1, 0, 3'd2, 32'h80000000, 32'h0, erd, eflt, lat);
    @(negedge clk);
    req_valid[1] = 1; req_we[1] = 0; f3[1] = 3'd2; addr[1] = 32'h80000000;
    @(posedge clk);
    #1 req_we[1] = 1; addr[1] = 32'h80000020; wdata[1] = 32'hA5A50F0F;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_ready", k), 32'(req_ready[1]), 32'd0);
      check($sformatf("hold%0d_valid", k), 32'(rsp_valid[1]), 32'd0);
    end
    @(negedge clk);
    check("hold_load_valid", 32'(rsp_valid[1]), 32'd1);
    check("hold_load_rdata", rdata[1], erd);
    check("hold_load_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1 req_valid[1] = 0;
    model(1, 1, 3'd2, 32'h80000020, 32'hA5A50F0F, erd, eflt, lat);
    @(negedge clk);
    check("hold_store_valid", 32'(rsp_valid[1]), 32'd1);
    check("hold_store_fault", 32'(fault[1]), 32'd0);
    check("hold_store_rdata", rdata[1], 32'd0);
    @(negedge clk);
    check("hold_pulse_end", 32'(rsp_valid[1]), 32'd0);
    xact(1, 0, 3'd2, 32'h80000020, 32'h0, rd, flt, erd, eflt);
    check("hold_store_readback", rd, 32'hA5A50F0F);

    // reset during WAIT of a 4-cycle load
    xact(2, 1, 3'd2, 32'h8, 32'h12345678, rd, flt, erd, eflt);
    check("pre_rst_store_fault", 32'(flt), 32'd0);
    @(negedge clk);
    req_valid[2] = 1; req_we[2] = 0; f3[2] = 3'd2; addr[2] = 32'h8;
    @(posedge clk);
    #1 req_valid[2] = 0;
    @(negedge clk);
    check("wait_before_rst", 32'(req_ready[2]), 32'd0);
    rst[2] = 1;
    #1;
    check("rst_async_ready", 32'(req_ready[2]), 32'd1);
    check("rst_async_valid", 32'(rsp_valid[2]), 32'd0);
    @(negedge clk);
    rst[2] = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("no_rsp_after_rst%0d", k), 32'(rsp_valid[2]), 32'd0);
    end
    xact(2, 0, 3'd2, 32'h8, 32'h0, rd, flt, erd, eflt);
    check("post_rst_readback", rd, 32'h12345678);
    check("post_rst_fault", 32'(flt), 32'd0);

    for (int u = 0; u < 3; u++)
      for (int n = 0; n < 150; n++) begin
        bit w = 1'($urandom_range(0, 1));
        bit [2:0] f = 3'($urandom_range(0, 7));
        bit [31:0] a = BASE[u] + 32'($urandom_range(0, 72)) - 32'd4;
        xact(u, w, f, a, $urandom, rd, flt, erd, eflt);
        check($sformatf("rnd u%0d a=%h f=%0d we=%0d rdata", u, a, f, w), rd, erd);
        check($sformatf("rnd u%0d a=%h f=%0d we=%0d fault", u, a, f, w), 32'(flt), 32'(eflt));
      end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end
endmodule
